// File: rtl/seg7_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// seg7_scan_driver : multiplexed 7-segment driver with blink, leading-zero
//   blanking and frame-synchronised loading; SEG7_DIM_EN adds PWM dimming.
// Revision 1.0
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 256,
  parameter int BLINK_DIV      = 16384,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_DIG = 0
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_Enable,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Bcd,
  input  logic [NUM_DIGITS-1:0]   i_Dots,
  input  logic [NUM_DIGITS-1:0]   i_Blink_Mask,
  input  logic                    i_Blank_Lead,
`ifdef SEG7_DIM_EN
  input  logic [3:0]              i_Brightness,
`endif
  output logic [7:0]              o_Segments,
  output logic [NUM_DIGITS-1:0]   o_Digits,
  output logic                    o_Frame_Done,
  output logic                    o_Blink_Phase
);

  localparam int c_REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [c_REF_W-1:0]    c_REF_LAST   = c_REF_W'(REFRESH_DIV - 1);
  localparam logic [c_SLOT_W-1:0]   c_SLOT_LAST  = c_SLOT_W'(NUM_DIGITS - 1);
  localparam logic [c_BLINK_W-1:0]  c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);
  localparam logic [7:0]            c_SEG_OFF    = (ACTIVE_LOW_SEG != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] c_DIG_OFF    = (ACTIVE_LOW_DIG != 0) ?
                                                   {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [c_REF_W-1:0]      r_refresh_cnt;
  logic [c_SLOT_W-1:0]     r_slot;
  logic [c_BLINK_W-1:0]    r_blink_cnt;
  logic                    r_blink_phase;
  logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
  logic [4*NUM_DIGITS-1:0] r_stage_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_dots;
  logic [NUM_DIGITS-1:0]   r_stage_dots;
  logic                    r_pending;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame_done;

  logic                    w_ref_tc;
  logic                    w_slot_tc;
  logic                    w_wrap;
  logic                    w_capture;
  logic                    w_blink_tc;
  logic                    w_phase_next;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_lead_blank;
  logic [3:0]              w_cur_bcd;
  logic                    w_cur_dot;
  logic                    w_cur_mask;
  logic                    w_cur_blank;
  logic [NUM_DIGITS-1:0]   w_slot_onehot;
  logic                    w_duty;
  logic                    w_dig_on;
  logic [7:0]              w_seg_act;
  logic [NUM_DIGITS-1:0]   w_dig_act;

  function automatic logic [6:0] f_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign w_ref_tc     = (r_refresh_cnt == c_REF_LAST);
  assign w_slot_tc    = (r_slot == c_SLOT_LAST);
  assign w_wrap       = i_Enable && w_ref_tc && w_slot_tc;
  assign w_capture    = !i_Enable || w_wrap;
  assign w_blink_tc   = (r_blink_cnt == c_BLINK_LAST);
  assign w_phase_next = w_blink_tc ? ~r_blink_phase : r_blink_phase;

  // Walk from the MSB down; blanking stops at the first nonzero digit, digit 0 never blanks.
  always_comb begin
    w_zero_run   = 1'b1;
    w_lead_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_run      = w_zero_run && (r_shadow_bcd[4*i +: 4] == 4'd0);
      w_lead_blank[i] = i_Blank_Lead && w_zero_run;
    end
  end

  always_comb begin
    w_cur_bcd     = 4'd0;
    w_cur_dot     = 1'b0;
    w_cur_mask    = 1'b0;
    w_cur_blank   = 1'b0;
    w_slot_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_slot == c_SLOT_W'(i)) begin
        w_cur_bcd        = r_shadow_bcd[4*i +: 4];
        w_cur_dot        = r_shadow_dots[i];
        w_cur_mask       = i_Blink_Mask[i];
        w_cur_blank      = w_lead_blank[i];
        w_slot_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SEG7_DIM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_pwm_cnt <= 4'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  assign w_duty = (r_pwm_cnt <= i_Brightness);
`else
  assign w_duty = 1'b1;
`endif

  // Blink gating uses the phase being registered this edge so o_Digits and o_Blink_Phase stay aligned.
  assign w_dig_on  = i_Enable && !w_cur_blank && !(w_phase_next && w_cur_mask) && w_duty;
  assign w_dig_act = w_dig_on ? w_slot_onehot : '0;
  assign w_seg_act = i_Enable ? {w_cur_dot, (w_cur_blank ? 7'b0000000 : f_decode(w_cur_bcd))}
                              : 8'h00;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_refresh_cnt <= '0;
      r_slot        <= '0;
    end else if (!i_Enable) begin
      r_refresh_cnt <= '0;
      r_slot        <= '0;
    end else if (w_ref_tc) begin
      r_refresh_cnt <= '0;
      r_slot        <= w_slot_tc ? '0 : r_slot + 1'b1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt   <= w_blink_tc ? '0 : r_blink_cnt + 1'b1;
      r_blink_phase <= w_phase_next;
    end
  end

  // The staging copy keeps the most recent load request until the frame boundary.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_shadow_bcd  <= '0;
      r_shadow_dots <= '0;
      r_stage_bcd   <= '0;
      r_stage_dots  <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (i_Load) begin
        r_stage_bcd  <= i_Bcd;
        r_stage_dots <= i_Dots;
      end
      if (w_capture) begin
        r_pending <= 1'b0;
        if (i_Load) begin
          r_shadow_bcd  <= i_Bcd;
          r_shadow_dots <= i_Dots;
        end else if (r_pending) begin
          r_shadow_bcd  <= r_stage_bcd;
          r_shadow_dots <= r_stage_dots;
        end
      end else if (i_Load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_seg        <= c_SEG_OFF;
      r_dig        <= c_DIG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_act ^ c_SEG_OFF;
      r_dig        <= w_dig_act ^ c_DIG_OFF;
      r_frame_done <= w_wrap;
    end
  end

  assign o_Segments    = r_seg;
  assign o_Digits      = r_dig;
  assign o_Frame_Done  = r_frame_done;
  assign o_Blink_Phase = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_seg7_scan_driver : scoreboard bench, 4 digits, REFRESH_DIV=4, BLINK_DIV=64.
// Revision 1.0
// ============================================================================
module tb_seg7_scan_driver;
  localparam int N = 4;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         en    = 1'b0;
  logic         load  = 1'b0;
  logic [15:0]  bcd   = 16'h0000;
  logic [3:0]   dots  = 4'h0;
  logic [3:0]   mask  = 4'h0;
  logic         bl    = 1'b0;
  logic [7:0]   seg, seg_al;
  logic [3:0]   dig, dig_al;
  logic         fd, fd_al, ph, ph_al;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(4), .BLINK_DIV(64), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_DIG(0)
  ) u_dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Load(load), .i_Bcd(bcd),
    .i_Dots(dots), .i_Blink_Mask(mask), .i_Blank_Lead(bl),
`ifdef SEG7_DIM_EN
    .i_Brightness(4'hF),
`endif
    .o_Segments(seg), .o_Digits(dig), .o_Frame_Done(fd), .o_Blink_Phase(ph)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(4), .BLINK_DIV(64), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_DIG(1)
  ) u_dut_al (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(en), .i_Load(load), .i_Bcd(bcd),
    .i_Dots(dots), .i_Blink_Mask(mask), .i_Blank_Lead(bl),
`ifdef SEG7_DIM_EN
    .i_Brightness(4'hF),
`endif
    .o_Segments(seg_al), .o_Digits(dig_al), .o_Frame_Done(fd_al), .o_Blink_Phase(ph_al)
  );

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic bit is_blank(input logic [15:0] v, input bit b, input int s);
    if (!b || s == 0) return 1'b0;
    for (int j = s; j < N; j++) if (v[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected slot-by-slot picture of one frame, pushed when the matching stimulus is driven.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dt, input bit b);
    exp_t e;
    for (int s = 0; s < N; s++) begin
      if (is_blank(v, b, s)) begin
        e.dig = 4'b0000;
        e.seg = {dt[s], 7'b0000000};
      end else begin
        e.dig = 4'(1 << s);
        e.seg = {dt[s], seg_pat(v[4*s +: 4])};
      end
      sb.push_back(e);
    end
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (fd === 1'b1) ok = 1'b1;
    end
  endtask

  // Disabled loads land at the next edge; re-enabling restarts the scan at slot 0.
  task automatic load_off(input logic [15:0] v, input logic [3:0] dt);
    @(negedge clk); en = 1'b0;
    @(negedge clk); bcd = v; dots = dt; load = 1'b1;
    @(negedge clk); load = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 8'h00 || dig !== 4'h0 || fd !== 1'b0 || ph !== 1'b0) begin
      errors++;
      $display("FAIL reset_hi seg=%b dig=%b fd=%b ph=%b, want 00000000 0000 0 0", seg, dig, fd, ph);
    end
    checks++;
    if (seg_al !== 8'hFF || dig_al !== 4'hF || fd_al !== 1'b0 || ph_al !== 1'b0) begin
      errors++;
      $display("FAIL reset_lo seg=%b dig=%b fd=%b ph=%b, want 11111111 1111 0 0", seg_al, dig_al, fd_al, ph_al);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    exp_t cur;
    load_off(16'h1234, 4'h0);
    push_frame(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
      checks++;
      if (dig !== cur.dig || seg !== cur.seg || fd !== (k == 15)) begin
        errors++;
        $display("FAIL scan k=%0d dig=%b seg=%b fd=%b, want dig=%b seg=%b fd=%b",
                 k, dig, seg, fd, cur.dig, cur.seg, k == 15);
      end
    end
  endtask

  task automatic test_blank_lead;
    exp_t cur;
    logic [15:0] vals [2];
    vals[0] = 16'h0042;
    vals[1] = 16'h0000;
    bl = 1'b1;
    for (int t = 0; t < 2; t++) begin
      load_off(vals[t], 4'h0);
      push_frame(vals[t], 4'h0, 1'b1);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
        checks++;
        if (dig !== cur.dig || seg !== cur.seg || fd !== (k == 15)) begin
          errors++;
          $display("FAIL blank v=%h k=%0d dig=%b seg=%b fd=%b, want dig=%b seg=%b",
                   vals[t], k, dig, seg, fd, cur.dig, cur.seg);
        end
      end
    end
    bl = 1'b0;
  endtask

  task automatic test_load_midframe;
    exp_t cur;
    bit   ok;
    load_off(16'h1234, 4'h0);
    push_frame(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
      checks++;
      if (dig !== cur.dig || seg !== cur.seg || fd !== (k == 15 || k == 31)) begin
        errors++;
        $display("FAIL midload k=%0d dig=%b seg=%b fd=%b, want dig=%b seg=%b",
                 k, dig, seg, fd, cur.dig, cur.seg);
      end
      if (k == 5) begin
        bcd = 16'h5678; load = 1'b1;
        push_frame(16'h5678, 4'h0, 1'b0);
      end
      if (k == 6) load = 1'b0;
    end
    bcd = 16'h00AF; dots = 4'b0001; load = 1'b1;
    push_frame(16'h00AF, 4'b0001, 1'b0);
    @(negedge clk); load = 1'b0;
    wait_fd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hexload_timeout fd=%b, want a frame pulse within 64 cycles", fd);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
      checks++;
      if (dig !== cur.dig || seg !== cur.seg || fd !== (k == 15)) begin
        errors++;
        $display("FAIL hexload k=%0d dig=%b seg=%b fd=%b, want dig=%b seg=%b",
                 k, dig, seg, fd, cur.dig, cur.seg);
      end
    end
    dots = 4'h0;
  endtask

  task automatic test_back_to_back;
    exp_t cur;
    bit   ok;
    wait_fd(ok);
    repeat (2) @(negedge clk);
    bcd = 16'h1111; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); bcd = 16'h2468; load = 1'b1;
    push_frame(16'h2468, 4'h0, 1'b0);
    @(negedge clk); load = 1'b0;
    wait_fd(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout fd=%b, want a frame pulse within 64 cycles", fd);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
      checks++;
      if (dig !== cur.dig || seg !== cur.seg) begin
        errors++;
        $display("FAIL b2b k=%0d dig=%b seg=%b, want dig=%b seg=%b", k, dig, seg, cur.dig, cur.seg);
      end
    end
  endtask

  task automatic test_blink;
    logic       prev_ph;
    int         last_tog;
    int         toggles;
    logic [3:0] seen;
    load_off(16'h1234, 4'h0);
    mask     = 4'b1100;
    last_tog = -1;
    toggles  = 0;
    seen     = 4'h0;
    prev_ph  = ph;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ph !== prev_ph) begin
        toggles++;
        if (last_tog >= 0) begin
          checks++;
          if (cyc - last_tog != 64) begin
            errors++;
            $display("FAIL blink_period got=%0d want=64", cyc - last_tog);
          end
          if (ph === 1'b1) begin
            checks++;
            if (seen !== 4'hF) begin
              errors++;
              $display("FAIL blink_phase0_lit seen=%b want=1111", seen);
            end
          end
        end
        last_tog = cyc;
        seen     = 4'h0;
      end
      if (ph === 1'b1) begin
        checks++;
        if (dig[3:2] !== 2'b00) begin
          errors++;
          $display("FAIL blink_masked dig=%b want dig[3:2]=00", dig);
        end
      end else begin
        seen = seen | dig;
      end
      prev_ph = ph;
    end
    checks++;
    if (toggles < 4) begin
      errors++;
      $display("FAIL blink_toggles got=%0d want>=4", toggles);
    end
    mask = 4'h0;
  endtask

  task automatic test_disable;
    exp_t cur;
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++;
      if (dig !== 4'h0 || fd !== 1'b0) begin
        errors++;
        $display("FAIL disabled i=%0d dig=%b fd=%b, want 0000 0", i, dig, fd);
      end
      if (i == 10) begin
        bcd = 16'h9876; dots = 4'h0; load = 1'b1;
        push_frame(16'h9876, 4'h0, 1'b0);
      end
      if (i == 11) load = 1'b0;
    end
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
      checks++;
      if (dig !== cur.dig || seg !== cur.seg || fd !== (k == 15)) begin
        errors++;
        $display("FAIL reenable k=%0d dig=%b seg=%b fd=%b, want dig=%b seg=%b",
                 k, dig, seg, fd, cur.dig, cur.seg);
      end
    end
  endtask

  task automatic test_reset_midslot;
    exp_t cur;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seg !== 8'h00 || dig !== 4'h0 || fd !== 1'b0 || ph !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_hi seg=%b dig=%b fd=%b ph=%b, want 00000000 0000 0 0", seg, dig, fd, ph);
    end
    checks++;
    if (seg_al !== 8'hFF || dig_al !== 4'hF) begin
      errors++;
      $display("FAIL async_reset_lo seg=%b dig=%b, want 11111111 1111", seg_al, dig_al);
    end
    @(negedge clk); rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0 && sb.size() > 0) cur = sb.pop_front();
      checks++;
      if (dig !== cur.dig || seg !== cur.seg || fd !== (k == 15)) begin
        errors++;
        $display("FAIL restart k=%0d dig=%b seg=%b fd=%b, want dig=%b seg=%b",
                 k, dig, seg, fd, cur.dig, cur.seg);
      end
      if (k < 4) begin
        checks++;
        if (seg_al !== 8'b11000000 || dig_al !== 4'b1110) begin
          errors++;
          $display("FAIL active_low k=%0d seg=%b dig=%b, want 11000000 1110", k, seg_al, dig_al);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank_lead();
    test_load_midframe();
    test_back_to_back();
    test_blink();
    test_disable();
    test_reset_midslot();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed 7-segment display driver for the clock designs.
- Generalises the fixed 4-digit scan in the current clock top: configurable digit count and output polarity.
- Adds per-digit blinking for setting modes, leading-zero blanking, and frame-synchronised (tear-free) data loading.
- Sits between the timekeeping/settings logic and the board's segment and digit pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 256, clocks per digit slot (>=2)
BLINK_DIV, 16384, clocks per blink half-period (>=2)
ACTIVE_LOW_SEG, 0, 1 = segment/dot outputs active-low
ACTIVE_LOW_DIG, 0, 1 = digit enables active-low

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  reset, asynchronous, active-low
i_Enable  in  1  scan enable; 0 = all digits dark
i_Load  in  1  request to latch i_Bcd/i_Dots into the display shadow
i_Bcd  in  4*NUM_DIGITS  packed BCD; digit 0 (rightmost) = [3:0]
i_Dots  in  NUM_DIGITS  decimal point per digit
i_Blink_Mask  in  NUM_DIGITS  digits that blink
i_Blank_Lead  in  1  suppress leading zeros
o_Segments  out  8  {dp,g,f,e,d,c,b,a}; "0" = 0_0111111 (active-high)
o_Digits  out  NUM_DIGITS  one-hot digit enable
o_Frame_Done  out  1  one-cycle pulse at end of full scan
o_Blink_Phase  out  1  current blink phase

Behaviour:
- Reset (async assert, sync release): counters, slot, phase, shadow and pending flag = 0. o_Segments and o_Digits at inactive level per polarity. o_Frame_Done = 0, o_Blink_Phase = 0.
- Refresh counter runs 0..REFRESH_DIV-1. At terminal count, slot advances 0..NUM_DIGITS-1 and wraps to 0.
- o_Frame_Done pulses on the cycle after the slot wraps NUM_DIGITS-1 -> 0.
- All outputs are registered. Output changes 1 cycle after the slot changes.
- Decode: BCD 0-9 uses the standard pattern. Codes 10-15 give segments a-g off; dp still follows i_Dots.
- Leading-zero blanking (i_Blank_Lead=1): zero digits from MSB down to the first nonzero have a-g off and their enable held inactive. Digit 0 is never blanked, so 0x0000 shows "0".
- Blink counter is free-running and independent of i_Enable. o_Blink_Phase toggles every BLINK_DIV clocks. While phase=1, digits with a mask bit set have their enable held inactive during their slot.
- Shadow load: i_Load sets a pending flag, and the shadow captures inputs at the next frame wrap. This gives no tearing within a frame.
  - If i_Load is high on the wrap cycle itself, the shadow captures directly at that edge.
  - Repeated i_Load before the wrap: the last value is captured at the wrap.
- i_Enable=0: refresh counter and slot held at 0, all digits inactive, no o_Frame_Done. Shadow loads are still accepted immediately at the next edge.
- On re-enable, scan restarts at slot 0.
- Polarity parameters invert only the final output registers; internal logic is active-high.

Optional Feature:
SEG7_DIM_EN
- Defined: adds input i_Brightness[3:0] and a free-running 4-bit PWM counter. The active digit enable is asserted only while pwm_cnt <= i_Brightness. 15 = full brightness, 0 = 1/16 duty. Segments are unaffected.
- Undefined: no port; enables are at full duty.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=64, active-high unless stated.
- Reset, load 0x1234, dots=0000, enable -> o_Digits 0001/0010/0100/1000 for 4 cycles each. Segments show 4 (01100110), then 3, 2, 1. o_Frame_Done pulses every 16 cycles.
- i_Blank_Lead=1, load 0x0042 -> slots 3 and 2 dark with segments 0, slot 1 shows 4, slot 0 shows 2. Load 0x0000 -> only digit 0 lit, showing 00111111.
- Mask 1100 -> during phase=1 (64 cycles), o_Digits[3:2] never set. During phase=0, all four slots lit. Phase toggles every 64 cycles.
- Pulse i_Load with 0x5678 at cycle 5 of a 0x1234 frame -> old digits until o_Frame_Done, new digits from the next slot 0. Load 0x00AF -> slots 0 and 1 have a-g off.
- Assert i_Reset_n=0 mid-slot with no clock edge -> outputs go inactive immediately. Deassert -> scan restarts at slot 0.
- ACTIVE_LOW_SEG=1, ACTIVE_LOW_DIG=1 -> "0" in slot 0 gives o_Segments=11000000, o_Digits=1110. Reset gives all ones.
